// File: rtl/commit_rob.sv
`default_nettype none

// +--------------------------------------------------------------------------+
// | commit_rob_pkg                                                           |
// | Shared types for the rename / ROB / writeback handshake.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package commit_rob_pkg;

    // Physical register reference: used for writeback, commit and sources.
    typedef struct packed {
        logic       valid;
        logic [5:0] idx;
        logic       ready;
    } p_reg_t;

    // Destination register of a renamed instruction.
    typedef struct packed {
        logic       valid;
        logic [5:0] idx;
    } rd_t;

    // Renamed instruction as delivered by the rename stage.
    typedef struct packed {
        logic   valid;
        rd_t    rd;
        p_reg_t rs1;
        p_reg_t rs2;
    } rinstr_t;

endpackage

// +--------------------------------------------------------------------------+
// | commit_rob                                                               |
// | In-order reorder buffer. Allocates renamed instructions at the tail,     |
// | marks them done on writeback, retires the head once done and reports    |
// | the retired physical destination to rename one cycle later.              |
// |                                                                          |
// | Ports:                                                                   |
// |   clk_i       - clock, all state on rising edge                          |
// |   rst_ni      - asynchronous active-low reset                            |
// |   rinstr_i    - renamed instruction (only valid and rd are used)         |
// |   wb_i        - writeback of physical register wb_i.idx                  |
// |   flush_i     - synchronous flush, discards every entry                  |
// |   p_commit_o  - registered in-order retirement of a physical rd          |
// |   rob_full_o  - no free entry                                            |
// |   rob_empty_o - no occupied entry                                        |
// |   count_o     - number of occupied entries                               |
// |   overflow_o  - sticky: valid instruction presented while full           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module commit_rob
    import commit_rob_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  rinstr_t                  rinstr_i,
    input  p_reg_t                   wb_i,
    input  logic                     flush_i,
    output p_reg_t                   p_commit_o,
    output logic                     rob_full_o,
    output logic                     rob_empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Pointers carry one extra wrap bit above the entry index.
    logic [AW:0]      r_head;
    logic [AW:0]      r_tail;
    logic [DEPTH-1:0] r_rd_valid;
    logic [DEPTH-1:0] r_done;
    logic [5:0]       r_rd_idx [DEPTH];
    p_reg_t           r_commit;
    logic             r_overflow;

    logic [AW-1:0]    w_head_idx;
    logic [AW-1:0]    w_tail_idx;
    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count;
    logic             w_alloc;
    logic             w_retire;
    logic             w_alloc_done;
    logic [DEPTH-1:0] w_wb_hit;
    logic             w_unused;

    assign w_head_idx = r_head[AW-1:0];
    assign w_tail_idx = r_tail[AW-1:0];

    assign w_full  = (w_head_idx == w_tail_idx) && (r_head[AW] != r_tail[AW]);
    assign w_empty = (r_head == r_tail);
    // Modular difference of the wrap-extended pointers is the occupancy.
    assign w_count = r_tail - r_head;

    // Refused when full even if the head leaves this cycle.
    assign w_alloc  = rinstr_i.valid && !w_full;
    assign w_retire = !w_empty && r_done[w_head_idx];

    // An entry without rd has nothing to wait for; a writeback arriving in
    // the allocation cycle is folded in so it is not lost.
    assign w_alloc_done = !rinstr_i.rd.valid ||
                          (wb_i.valid && (wb_i.idx == rinstr_i.rd.idx));

    // Writeback only touches entries that are currently occupied, i.e. whose
    // distance from the head is below the occupancy.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [AW-1:0] w_off;
        assign w_off = AW'(gi) - w_head_idx;
        assign w_wb_hit[gi] = wb_i.valid && r_rd_valid[gi] &&
                              (r_rd_idx[gi] == wb_i.idx) &&
                              ({1'b0, w_off} < w_count);
    end

    // Source operands and writeback ready do not influence the ROB.
    assign w_unused = ^{rinstr_i.rs1, rinstr_i.rs2, wb_i.ready};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_rd_valid <= '0;
            r_done     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rd_idx[i] <= '0;
            end
            r_commit   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (rinstr_i.valid && w_full) begin
                r_overflow <= 1'b1;
            end

            if (flush_i) begin
                r_head   <= '0;
                r_tail   <= '0;
                r_done   <= '0;
                r_commit <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_wb_hit[i]) begin
                        r_done[i] <= 1'b1;
                    end
                end

                // Later assignment wins over a stale writeback hit on the
                // free tail slot.
                if (w_alloc) begin
                    r_rd_valid[w_tail_idx] <= rinstr_i.rd.valid;
                    r_rd_idx[w_tail_idx]   <= rinstr_i.rd.idx;
                    r_done[w_tail_idx]     <= w_alloc_done;
                    r_tail                 <= r_tail + CW'(1);
                end

                if (w_retire) begin
                    r_head         <= r_head + CW'(1);
                    r_commit.valid <= r_rd_valid[w_head_idx];
                    r_commit.idx   <= r_rd_idx[w_head_idx];
                    r_commit.ready <= 1'b1;
                end else begin
                    r_commit <= '0;
                end
            end
        end
    end

    assign p_commit_o  = r_commit;
    assign rob_full_o  = w_full;
    assign rob_empty_o = w_empty;
    assign count_o     = w_count;
    assign overflow_o  = r_overflow;

endmodule

`default_nettype wire

// File: doc/commit_rob.md
COMMIT_ROB -- requirements
Module: commit_rob

Interface
REQ-001 Parameter DEPTH, default 8, ROB entry count; SHALL be a power of two, 2..32.
REQ-002 Port clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_ni  input  1  reset; asynchronous, active-low.
REQ-004 Port rinstr_i  input  rinstr_t  renamed instruction from rename (valid, rd{valid,idx[5:0]}, rs1/rs2{valid,idx,ready}).
REQ-005 Port wb_i  input  p_reg_t  writeback; valid with idx marks physical register idx produced.
REQ-006 Port flush_i  input  1  synchronous pipeline flush; discards all entries.
REQ-007 Port p_commit_o  output  p_reg_t  in-order retirement of a physical rd, to rename p_commit_i.
REQ-008 Port rob_full_o  output  1  no free entry; drives the rename back-pressure path.
REQ-009 Port rob_empty_o  output  1  no occupied entry.
REQ-010 Port count_o  output  $clog2(DEPTH)+1  occupied entries.
REQ-011 Port overflow_o  output  1  sticky: valid rinstr_i presented while full.

Function
REQ-012 Storage SHALL be a circular FIFO: head/tail pointers of $clog2(DEPTH) bits plus one wrap bit; full = equal index with differing wrap bits; empty = pointers equal.
REQ-013 Entry fields: rd_valid, rd_idx[5:0], done.
REQ-014 Allocate at tail when rinstr_i.valid && !rob_full_o; tail advances by one, wrapping DEPTH-1 -> 0.
REQ-015 Allocated done = 1 when rinstr_i.rd.valid = 0, or when wb_i.valid && wb_i.idx == rinstr_i.rd.idx in the same cycle; otherwise 0.
REQ-016 wb_i.valid SHALL set done on every occupied entry with rd_valid && rd_idx == wb_i.idx; wb_i with no match SHALL be ignored.
REQ-017 Retire: at most one entry per cycle, the head, when occupied and its registered done = 1; head advances with wrap.
REQ-018 p_commit_o SHALL be registered: the cycle after a retire edge it carries valid = head rd_valid, idx = head rd_idx, ready = 1; otherwise valid = 0, idx = 0, ready = 0.
REQ-019 Entries lacking rd retire without p_commit_o.valid.
REQ-020 Latency: wb_i in cycle N -> done at edge N -> retire at edge N+1 -> p_commit_o.valid in cycle N+2.
REQ-021 rob_full_o, rob_empty_o, count_o SHALL be combinational from registered pointers only; allocate and retire in one cycle leave count unchanged.
REQ-022 When full, allocation is refused even if the head retires that cycle; the instruction is dropped and overflow_o sets, clearing only on reset.
REQ-023 flush_i = 1 SHALL have priority over allocate, retire and writeback: pointers zeroed, all done cleared, next-cycle p_commit_o = '0; overflow_o retained.
REQ-024 rinstr_i.rs1/rs2 SHALL not affect state.

Reset
REQ-025 Reset SHALL asynchronously force head = tail = 0, all done/rd_valid = 0, p_commit_o = '0, overflow_o = 0; hence rob_empty_o = 1, rob_full_o = 0, count_o = 0.
REQ-026 Reset asserted mid-operation SHALL discard all entries and any p_commit_o pending for the next cycle.

Verification
REQ-027 Reset then allocate rd=33, rd=34, no-rd entry; wb idx 34 cycle 5, idx 33 cycle 7 -> p_commit_o {1,33,1} cycle 9, {1,34,1} cycle 10, no-rd retires cycle 10 silently, count_o 0 by cycle 11.
REQ-028 DEPTH=8: allocate 8 rd entries, no wb -> rob_full_o = 1, count_o = 8; 9th valid rinstr_i -> dropped, overflow_o = 1, count_o stays 8.
REQ-029 Full ROB, head done, rinstr_i valid same cycle -> head retires, no allocation, count_o 7, overflow_o = 1.
REQ-030 Same-cycle allocate rd=40 with wb_i idx 40 into empty ROB -> retire next cycle, p_commit_o {1,40,1} two cycles after allocation.
REQ-031 Allocate 12 and retire 12 with DEPTH=8 -> pointers wrap; commit order matches allocation order.
REQ-032 flush_i with 5 entries, one retiring that cycle -> next cycle p_commit_o.valid = 0, count_o = 0, rob_empty_o = 1; then assert rst_ni low mid-stream -> outputs immediately reset values.
